// File: rtl/cache_mem_bridge.sv
// Cache-to-memory bridge: request FIFO, in-flight cap, seq tagging in opaque, response order check.
// Optional macro CACHE_MEM_BRIDGE_RESP_BUF_EN adds a 2-entry registered response skid buffer.
package cache_mem_bridge_pkg;
  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

module cache_mem_bridge
  import cache_mem_bridge_pkg::*;
#(
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cache_req_val,
  output logic                             cache_req_rdy,
  input  mem_req_4B_t                      cache_req_msg,
  output logic                             cache_resp_val,
  input  logic                             cache_resp_rdy,
  output mem_resp_4B_t                     cache_resp_msg,
  output logic                             mem_req_val,
  input  logic                             mem_req_rdy,
  output mem_req_4B_t                      mem_req_msg,
  input  logic                             mem_resp_val,
  output logic                             mem_resp_rdy,
  input  mem_resp_4B_t                     mem_resp_msg,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             idle,
  output logic                             order_err
);
  localparam int RAW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int RCW = $clog2(REQ_DEPTH) + 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;

  typedef struct packed {
    logic [7:0] orig_opaque;
    logic [7:0] seq;
  } tag_t;

  mem_req_4B_t    req_mem [REQ_DEPTH];
  tag_t           tag_mem [MAX_OUTSTANDING];
  logic [RAW-1:0] req_wr_ptr, req_rd_ptr;
  logic [TAW-1:0] tag_wr_ptr, tag_rd_ptr;
  logic [RCW-1:0] req_count, req_count_next;
  logic [OCW-1:0] outstanding_next;
  logic [7:0]     seq;
  logic           req_full, req_empty, solicited;
  logic           cache_req_fire, mem_req_fire, mem_resp_fire;
  logic           tag_pop, err_set, resp_empty_next;
  tag_t           tag_head;
  mem_resp_4B_t   fwd_msg;

  // Every handshake output is forced low while reset is held.
  assign req_full       = (req_count == RCW'(REQ_DEPTH));
  assign req_empty      = (req_count == '0);
  assign cache_req_rdy  = reset && !req_full;
  assign cache_req_fire = cache_req_val && cache_req_rdy;
  assign mem_req_val    = reset && !req_empty && (outstanding < OCW'(MAX_OUTSTANDING));
  assign mem_req_fire   = mem_req_val && mem_req_rdy;

  always_comb begin
    mem_req_msg        = req_mem[req_rd_ptr];
    mem_req_msg.opaque = seq;
  end

  // Tag FIFO occupancy always equals outstanding, so it needs no count of its own.
  assign solicited = (outstanding != '0);
  assign tag_head  = tag_mem[tag_rd_ptr];
  assign tag_pop   = mem_resp_fire && solicited;
  assign err_set   = mem_resp_fire && (!solicited || (mem_resp_msg.opaque != tag_head.seq));

  always_comb begin
    fwd_msg        = mem_resp_msg;
    fwd_msg.opaque = tag_head.orig_opaque;
  end

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_count_next = req_count;
    case ({cache_req_fire, mem_req_fire})
      2'b10:   req_count_next = req_count + RCW'(1);
      2'b01:   req_count_next = req_count - RCW'(1);
      default: ;
    endcase
  end

  always_comb begin
    outstanding_next = outstanding;
    case ({mem_req_fire, tag_pop})
      2'b10:   outstanding_next = outstanding + OCW'(1);
      2'b01:   outstanding_next = outstanding - OCW'(1);
      default: ;
    endcase
  end

  // NOTE: payload arrays carry no reset; pointers and counts alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (cache_req_fire) req_mem[req_wr_ptr] <= cache_req_msg;
    if (mem_req_fire)   tag_mem[tag_wr_ptr] <= tag_t'{orig_opaque: req_mem[req_rd_ptr].opaque, seq: seq};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_wr_ptr  <= '0;
      req_rd_ptr  <= '0;
      tag_wr_ptr  <= '0;
      tag_rd_ptr  <= '0;
      req_count   <= '0;
      outstanding <= '0;
      seq         <= '0;
      order_err   <= 1'b0;
      idle        <= 1'b1;
    end else begin
      if (cache_req_fire) req_wr_ptr <= req_wr_ptr + RAW'(1);
      if (mem_req_fire) begin
        req_rd_ptr <= req_rd_ptr + RAW'(1);
        tag_wr_ptr <= (tag_wr_ptr == TAW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_ptr + TAW'(1);
        seq        <= seq + 8'd1;
      end
      if (tag_pop) tag_rd_ptr <= (tag_rd_ptr == TAW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_ptr + TAW'(1);
      if (err_set) order_err <= 1'b1;
      req_count   <= req_count_next;
      outstanding <= outstanding_next;
      idle        <= (req_count_next == '0) && (outstanding_next == '0) && resp_empty_next;
    end
  end

`ifdef CACHE_MEM_BRIDGE_RESP_BUF_EN
  mem_resp_4B_t buf_mem [2];
  logic         buf_wr_ptr, buf_rd_ptr, buf_push, buf_pop;
  logic [1:0]   buf_count, buf_count_next;

  // Unsolicited responses are still drained so memory never stalls on them.
  assign mem_resp_rdy    = reset && ((buf_count != 2'd2) || !solicited);
  assign mem_resp_fire   = mem_resp_val && mem_resp_rdy;
  assign buf_push        = mem_resp_fire && solicited;
  assign cache_resp_val  = reset && (buf_count != 2'd0);
  assign buf_pop         = cache_resp_val && cache_resp_rdy;
  assign cache_resp_msg  = buf_mem[buf_rd_ptr];
  assign resp_empty_next = (buf_count_next == 2'd0);

  always_comb begin
    buf_count_next = buf_count;
    case ({buf_push, buf_pop})
      2'b10:   buf_count_next = buf_count + 2'd1;
      2'b01:   buf_count_next = buf_count - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (buf_push) buf_mem[buf_wr_ptr] <= fwd_msg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_wr_ptr <= 1'b0;
      buf_rd_ptr <= 1'b0;
      buf_count  <= 2'd0;
    end else begin
      if (buf_push) buf_wr_ptr <= ~buf_wr_ptr;
      if (buf_pop)  buf_rd_ptr <= ~buf_rd_ptr;
      buf_count <= buf_count_next;
    end
  end
`else
  assign mem_resp_rdy    = reset && (solicited ? cache_resp_rdy : 1'b1);
  assign mem_resp_fire   = mem_resp_val && mem_resp_rdy;
  assign cache_resp_val  = reset && mem_resp_val && solicited;
  assign cache_resp_msg  = fwd_msg;
  assign resp_empty_next = 1'b1;
`endif

endmodule
